// File: rtl/car_pkg.sv
// Shared definitions for the manual-car driver: car FSM encodings, command
// opcodes, control patterns and the driver's registered output bundle.
package car_pkg;

    // States reported by the downstream manual car FSM
    localparam logic [1:0] ST_NOT_STARTING = 2'b00;
    localparam logic [1:0] ST_STARTING     = 2'b01;
    localparam logic [1:0] ST_MOVING       = 2'b10;

    // Command opcodes (2'b11 is reserved and behaves like STOP)
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_FWD  = 2'b01;
    localparam logic [1:0] OP_BWD  = 2'b10;

    // Control patterns as {throttle, reverse, clutch, brake}; the reverse
    // slot is filled with the direction where a pattern carries one.
    localparam logic [3:0] PAT_ENGAGE   = 4'b1010;
    localparam logic [3:0] PAT_LAUNCH   = 4'b1000;
    localparam logic [3:0] PAT_DECLUTCH = 4'b0010;
    localparam logic [3:0] PAT_BRAKE    = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENGAGE   = 3'd1,
        S_LAUNCH   = 3'd2,
        S_CRUISE   = 3'd3,
        S_DECLUTCH = 3'd4,
        S_BRAKE    = 3'd5,
        S_FAULT    = 3'd6
    } fsm_e;

    // Everything the driver presents downstream, registered as one word
    typedef struct packed {
        logic throttle;
        logic reverse;
        logic clutch;
        logic brake;
        logic bu_left;
        logic bu_right;
        logic busy;
    } drv_out_t;

    localparam drv_out_t OUT_IDLE  = drv_out_t'(7'b0000_00_0);
    localparam drv_out_t OUT_FAULT = drv_out_t'({PAT_BRAKE, 2'b00, 1'b1});

    // Output word for an active phase: pattern, direction and turn buttons
    function automatic drv_out_t mk_out(input logic [3:0] pat, input logic rev,
                                        input logic [1:0] bu);
        drv_out_t o;
        o.throttle = pat[3];
        o.reverse  = pat[2] | rev;
        o.clutch   = pat[1];
        o.brake    = pat[0];
        o.bu_left  = bu[1];
        o.bu_right = bu[0];
        o.busy     = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/manual_autodriver_phase_timer.sv
// Phase timer: counts cycles spent in the current wait phase and flags when
// the minimum hold has been met and when the phase has run out of time.
// i_clear marks the first cycle of a phase; the flags already account for it.
module phase_timer #(
    parameter int HOLD_MIN = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_hold_met,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_held;

    // Cycles held including the current one, saturating at TIMEOUT
    always_comb begin
        w_base = i_clear ? '0 : r_cnt;
        w_held = (w_base == C_MAX) ? C_MAX : w_base + 1'b1;
    end

    assign o_hold_met = (w_held >= CW'(HOLD_MIN));
    assign o_expired  = (w_held >= C_MAX);

    // Keep the running count for the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_held;
    end

endmodule

// File: rtl/manual_autodriver.sv
// Scripted driver for the manual car FSM. Turns STOP/FWD/BWD commands into
// clutch/throttle/brake/reverse/turn sequences, advancing each phase only
// when the car's reported state confirms it.
// Command handshake: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high; cmd_ready is high only in IDLE, and any
// cmd_valid seen while busy is dropped, never queued.
module manual_autodriver
    import car_pkg::*;
#(
    parameter int HOLD_MIN = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_turn,
    input  logic [7:0] cmd_len,
    input  logic [1:0] state,
    output logic       clutch,
    output logic       throttle,
    output logic       brake,
    output logic       reverse,
    output logic       bu_left,
    output logic       bu_right,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] o_dbg_fsm
);
    fsm_e       r_fsm;
    fsm_e       r_fsm_prev;
    drv_out_t   r_out;
    logic       r_done;
    logic       r_err;
    logic       r_rev;
    logic       r_restart;
    logic [1:0] r_turn;
    logic [7:0] r_len;
    logic [7:0] r_cruise_cnt;

    logic       w_phase_start;
    logic       w_hold_met;
    logic       w_expired;
    logic       w_cmd_move;
    logic       w_cmd_rev;
    logic [1:0] w_cmd_turn;
    logic [1:0] w_cur;
    logic [1:0] w_tgt;
    logic       w_wait_bad;
    logic       w_advance;
    logic [7:0] w_cruise_base;
    logic [7:0] w_cruise_held;

    // A phase starts on the first cycle after the FSM changes state
    assign w_phase_start = (r_fsm != r_fsm_prev);

    assign w_cmd_move = (cmd_op == OP_FWD) || (cmd_op == OP_BWD);
    assign w_cmd_rev  = (cmd_op == OP_BWD);
    assign w_cmd_turn = (cmd_turn == 2'b11) ? 2'b00 : cmd_turn;

    phase_timer #(
        .HOLD_MIN (HOLD_MIN),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_phase_start),
        .o_hold_met (w_hold_met),
        .o_expired  (w_expired)
    );

    // Car state expected on entry to each wait phase and the one that ends it
    always_comb begin
        w_cur = ST_NOT_STARTING;
        w_tgt = ST_NOT_STARTING;
        case (r_fsm)
            S_ENGAGE:   begin w_cur = ST_NOT_STARTING; w_tgt = ST_STARTING;     end
            S_LAUNCH:   begin w_cur = ST_STARTING;     w_tgt = ST_MOVING;       end
            S_DECLUTCH: begin w_cur = ST_MOVING;       w_tgt = ST_STARTING;     end
            S_BRAKE:    begin w_cur = ST_STARTING;     w_tgt = ST_NOT_STARTING; end
            default:    begin w_cur = ST_NOT_STARTING; w_tgt = ST_NOT_STARTING; end
        endcase
    end

    assign w_wait_bad = (state != w_cur) && (state != w_tgt);
    assign w_advance  = w_hold_met && (state == w_tgt);

    // Cruise cycles held including the current one, saturating at 255
    always_comb begin
        w_cruise_base = w_phase_start ? 8'd0 : r_cruise_cnt;
        w_cruise_held = (w_cruise_base == 8'hFF) ? 8'hFF : w_cruise_base + 8'd1;
    end

    // Cruise counter and previous-state tracking for phase entry detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cruise_cnt <= '0;
            r_fsm_prev   <= S_IDLE;
        end else begin
            r_cruise_cnt <= w_cruise_held;
            r_fsm_prev   <= r_fsm;
        end
    end

    // Command sequencer; every transition also loads the output pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= S_IDLE;
            r_out     <= OUT_IDLE;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rev     <= 1'b0;
            r_restart <= 1'b0;
            r_turn    <= '0;
            r_len     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rev     <= w_cmd_rev;
                        r_turn    <= w_cmd_turn;
                        r_len     <= cmd_len;
                        r_restart <= w_cmd_move && (state != ST_NOT_STARTING);
                        // The car is always brought to rest before a direction is set
                        if (state == ST_MOVING) begin
                            r_fsm <= S_DECLUTCH;
                            r_out <= mk_out(PAT_DECLUTCH, 1'b0, 2'b00);
                        end else if (state == ST_STARTING) begin
                            r_fsm <= S_BRAKE;
                            r_out <= mk_out(PAT_BRAKE, 1'b0, 2'b00);
                        end else if (!w_cmd_move) begin
                            r_done <= 1'b1;
                        end else if (state == ST_NOT_STARTING) begin
                            r_fsm <= S_ENGAGE;
                            r_out <= mk_out(PAT_ENGAGE, w_cmd_rev, 2'b00);
                        end else begin
                            r_fsm <= S_FAULT;
                            r_out <= OUT_FAULT;
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ENGAGE, S_LAUNCH, S_DECLUTCH, S_BRAKE: begin
                    if (w_wait_bad || (!w_advance && w_expired)) begin
                        r_fsm <= S_FAULT;
                        r_out <= OUT_FAULT;
                        r_err <= 1'b1;
                    end else if (w_advance) begin
                        case (r_fsm)
                            S_ENGAGE: begin
                                r_fsm <= S_LAUNCH;
                                r_out <= mk_out(PAT_LAUNCH, r_rev, 2'b00);
                            end
                            S_LAUNCH: begin
                                if (r_len == 8'd0) begin
                                    r_fsm <= S_DECLUTCH;
                                    r_out <= mk_out(PAT_DECLUTCH, 1'b0, 2'b00);
                                end else begin
                                    r_fsm <= S_CRUISE;
                                    r_out <= mk_out(PAT_LAUNCH, r_rev, r_turn);
                                end
                            end
                            S_DECLUTCH: begin
                                r_fsm <= S_BRAKE;
                                r_out <= mk_out(PAT_BRAKE, 1'b0, 2'b00);
                            end
                            default: begin
                                if (r_restart) begin
                                    r_restart <= 1'b0;
                                    r_fsm     <= S_ENGAGE;
                                    r_out     <= mk_out(PAT_ENGAGE, r_rev, 2'b00);
                                end else begin
                                    r_fsm  <= S_IDLE;
                                    r_out  <= OUT_IDLE;
                                    r_done <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_CRUISE: begin
                    if (state != ST_MOVING) begin
                        r_fsm <= S_FAULT;
                        r_out <= OUT_FAULT;
                        r_err <= 1'b1;
                    end else if (w_cruise_held == r_len) begin
                        r_fsm <= S_DECLUTCH;
                        r_out <= mk_out(PAT_DECLUTCH, 1'b0, 2'b00);
                    end
                end
                S_FAULT: begin
                    r_out <= OUT_FAULT;
                end
                default: begin
                    r_fsm <= S_FAULT;
                    r_out <= OUT_FAULT;
                    r_err <= 1'b1;
                end
            endcase
        end
    end

    assign {throttle, reverse, clutch, brake, bu_left, bu_right, busy} = r_out;
    assign cmd_ready = (r_fsm == S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign o_dbg_fsm = r_fsm;

endmodule

// File: doc/manual_autodriver.md
# manual_autodriver

Scripted driver for the manual-transmission car FSM (`manual`). It accepts high-level drive commands and produces the clutch/throttle/brake/reverse/turn-button control sequence that the `manual` block consumes. It closes the loop by watching `manual`'s `state` output, so each gear phase advances only when the car FSM confirms the transition. It sits beside the manual-mode controls and is muxed onto `manual`'s inputs when autodrive is selected.

## Interface
- `HOLD_MIN`, default 2: minimum cycles each control pattern is held before the block checks `state`.
- `TIMEOUT`, default 64: maximum cycles to wait for a `state` transition before faulting.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: block can accept a command; equals (fsm == IDLE).
- `cmd_op`  in  2: 00 STOP, 01 FWD, 10 BWD, 11 reserved (accepted, treated as STOP).
- `cmd_turn`  in  2: {left,right} held during cruise; 11 treated as 00.
- `cmd_len`  in  8: cruise duration in cycles.
- `state`  in  2: `manual` FSM state, NOT_STARTING=00, STARTING=01, MOVING=10.
- `clutch`, `throttle`, `brake`, `reverse`, `bu_left`, `bu_right`  out  1 each: registered controls to `manual`.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle pulse on command completion.
- `err`  out  1: sticky fault flag.

## Operation
- The control patterns driven to `manual`, written as {throttle,reverse,clutch,brake}:
  - ENGAGE: 1r10, where r=1 for BWD.
  - LAUNCH: 1r00.
  - DECLUTCH: 0010.
  - BRAKE: 0001.
- FSM states: IDLE, ENGAGE, LAUNCH, CRUISE, DECLUTCH, BRAKE, FAULT.
- IDLE drives all controls 0. On `cmd_valid & cmd_ready`, the block latches op/turn/len.
  - FWD/BWD with `state`==00 goes to ENGAGE.
  - FWD/BWD with `state`==01 goes to BRAKE first, then restarts at ENGAGE.
  - FWD/BWD with `state`==10 goes to DECLUTCH, then BRAKE, then ENGAGE. The car is always stopped before a direction is set.
  - STOP goes to DECLUTCH if `state`==10, to BRAKE if `state`==01, and otherwise completes at once (`done` is pulsed).
- Wait phases (ENGAGE, LAUNCH, DECLUTCH, BRAKE) hold their pattern for at least HOLD_MIN cycles. After that, the phase exits on the first cycle its target `state` is seen:
  - ENGAGE exits on 01 to LAUNCH.
  - LAUNCH exits on 10 to CRUISE.
  - DECLUTCH exits on 01 to BRAKE.
  - BRAKE exits on 00 to IDLE, or to ENGAGE if a pending restart is flagged.
- CRUISE holds 1r00, with `bu_left`/`bu_right` = latched `cmd_turn`, for exactly `cmd_len` cycles, then goes to DECLUTCH. If `cmd_len`==0, CRUISE lasts 0 cycles (LAUNCH goes directly to DECLUTCH).
- Any `state` other than the current or target value during a wait phase, or any `state` other than 10 during CRUISE, causes FAULT.
- Timeout: a wait phase still unresolved at TIMEOUT cycles causes FAULT.
- FAULT drives `brake`=1 with all other controls 0, sets `err`=1, holds `busy`=1 and `cmd_ready`=0, and stays there until `rst`.
- `bu_left`/`bu_right` are 0 in every state except CRUISE.
- Counters: the 8-bit cruise counter and the phase counter (width clog2(TIMEOUT+1)) both saturate and never wrap.

## Timing
- Reset values: all controls 0, `busy` 0, `done` 0, `err` 0, FSM in IDLE, so `cmd_ready`=1 during and after reset.
- Command accepted on clock edge N: the first pattern appears on the outputs after edge N, and `busy`=1 from that point.
- A `state` target sampled at edge M causes the next phase's pattern to be output after edge M (one-cycle reaction).
- `done` is high for the single cycle after the edge that returns the FSM to IDLE. `busy` falls in that same cycle.
- `cmd_valid` while busy is ignored: it is neither accepted nor queued, and `cmd_ready`=0.
- `rst` mid-command: outputs go to 0 immediately (asynchronous). The downstream `manual` FSM is not reset by this block.

## Structure
- Shared package `car_pkg`:
  - `manual` state encodings (NOT_STARTING, STARTING, MOVING).
  - `cmd_op` encodings.
  - Control-pattern constants (ENGAGE, LAUNCH, DECLUTCH, BRAKE).
- Optional sub-module `phase_timer`: phase counter with HOLD_MIN-met and TIMEOUT-expired flags, cleared on phase entry.
- The FSM and the output registers stay in `manual_autodriver`.

## Test plan
- Reset, then FWD with turn=00, len=5, connected to `manual`: patterns 1010 → 1000, 5 cruise cycles, then 0010 → 0001. `done` pulses and `state` ends at 00.
- BWD with turn=10, len=3: `reverse`=1 in ENGAGE/LAUNCH/CRUISE. `bu_left`=1 for exactly 3 cycles, `bu_right`=0 throughout.
- A second FWD issued while MOVING is refused (`cmd_ready`=0). After `done`, the accepted FWD with `state` forced to 10 passes through DECLUTCH and BRAKE before ENGAGE.
- Stubbed `state` held at 00 during ENGAGE with TIMEOUT=64: FAULT at cycle 64, `brake`=1, `err`=1, new commands refused.
- FWD with len=0: LAUNCH goes directly to DECLUTCH with no throttle-only cruise cycle. STOP in IDLE with `state`=00 gives a `done` pulse one cycle after acceptance.
- `rst` asserted mid-CRUISE: all outputs 0 immediately, `cmd_ready`=1 after release.
